// File: rtl/avalon_mm_pkg.sv
// Shared types and helpers for the multi-port Avalon-MM master.
// Access sizes, FSM states and the bus lane-count helper live here.
package avalon_mm_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Number of byte lanes on a bus of the given data width.
   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/avalon_lane_steer.sv
// Combinational byte-lane steering: places write data and byte enables on the
// addressed lanes, extracts and extends read data, and flags illegal accesses.
module avalon_lane_steer
   import avalon_mm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANES  = lanes(DATA_W),
   parameter int L      = $clog2(LANES)
) (
   input  size_e             size,
   input  logic [L-1:0]      off,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] readdata,
   output logic [DATA_W-1:0] writedata,
   output logic [LANES-1:0]  byteenable,
   output logic [DATA_W-1:0] rdata,
   output logic              misaligned
);

   logic [DATA_W-1:0] size_mask;
   logic [LANES-1:0]  be_base;
   logic [DATA_W-1:0] shifted;
   logic              sign_bit;

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      size_mask  = '1;
      be_base    = '1;
      sign_bit   = 1'b0;
      misaligned = 1'b0;
      shifted    = readdata >> {off, 3'b000};

      case (size)
         SZ_BYTE: begin
            size_mask = DATA_W'(8'hFF);
            be_base   = LANES'(8'h01);
            sign_bit  = shifted[7];
         end
         SZ_HALF: begin
            size_mask  = DATA_W'(16'hFFFF);
            be_base    = LANES'(8'h03);
            sign_bit   = shifted[15];
            misaligned = off[0];
         end
         SZ_WORD: begin
            size_mask  = DATA_W'(32'hFFFF_FFFF);
            be_base    = LANES'(8'h0F);
            sign_bit   = shifted[31];
            misaligned = (off[1:0] != 2'b00);
         end
         default: begin
            // A dword fills the whole 64-bit bus; on a 32-bit bus it cannot be issued.
            size_mask  = '1;
            be_base    = '1;
            sign_bit   = 1'b0;
            misaligned = (DATA_W < 64) || (off != '0);
         end
      endcase

      writedata  = (wdata & size_mask) << {off, 3'b000};
      byteenable = be_base << off;
      rdata      = (shifted & size_mask) | ((is_signed && sign_bit) ? ~size_mask : '0);
   end

endmodule

// File: rtl/avalon_mm_multiport_master.sv
// Arbitrates NUM_PORTS valid/ready requesters onto one Avalon-MM master port,
// with lane steering, sign extension and misalignment detection.
module avalon_mm_multiport_master
   import avalon_mm_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int RR_MODE   = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        req_valid,
   output logic [NUM_PORTS-1:0]        req_ready,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*2-1:0]      req_size,
   input  logic [NUM_PORTS-1:0]        req_signed,
   input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]        rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        rsp_err,
   output logic [ADDR_W-1:0]           address,
   output logic                        read,
   output logic                        write,
   input  logic                        waitrequest,
   output logic [DATA_W-1:0]           writedata,
   output logic [DATA_W/8-1:0]         byteenable,
   input  logic [DATA_W-1:0]           readdata
);

   localparam int LANES = lanes(DATA_W);
   localparam int L     = $clog2(LANES);
   localparam int IDW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   state_e state, next_state;

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant_id;
   logic           grant_found;
   logic           accept;
   int             arb_idx;

   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   size_e             win_size;
   logic              win_signed;
   logic              win_write;

   logic [IDW-1:0] lat_id;
   logic           lat_write;
   size_e          lat_size;
   logic           lat_signed;
   logic [L-1:0]   lat_off;

   size_e             sel_size;
   logic [L-1:0]      sel_off;
   logic              sel_signed;
   logic [DATA_W-1:0] steer_wdata;
   logic [LANES-1:0]  steer_be;
   logic [DATA_W-1:0] steer_rdata;
   logic              steer_misaligned;

   // Arbiter: round-robin starts one past the last winner; fixed priority starts at 0.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      arb_idx     = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (RR_MODE != 0) arb_idx = (int'(rr_ptr) + 1 + k) % NUM_PORTS;
         else              arb_idx = k;
         if (!grant_found && req_valid[arb_idx]) begin
            grant_found = 1'b1;
            grant_id    = IDW'(arb_idx);
         end
      end
   end

   assign accept = reset && (state == ST_IDLE) && grant_found;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      win_addr   = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
      win_wdata  = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
      win_size   = size_e'(req_size[int'(grant_id)*2 +: 2]);
      win_signed = req_signed[grant_id];
      win_write  = req_write[grant_id];
   end

   // One steering instance: fed by the winner while idle, by the latched request afterwards.
   always_comb begin
      sel_size   = lat_size;
      sel_off    = lat_off;
      sel_signed = lat_signed;
      if (state == ST_IDLE) begin
         sel_size   = win_size;
         sel_off    = win_addr[L-1:0];
         sel_signed = win_signed;
      end
   end

   avalon_lane_steer #(
      .DATA_W (DATA_W)
   ) u_steer (
      .size       (sel_size),
      .off        (sel_off),
      .is_signed  (sel_signed),
      .wdata      (win_wdata),
      .readdata   (readdata),
      .writedata  (steer_wdata),
      .byteenable (steer_be),
      .rdata      (steer_rdata),
      .misaligned (steer_misaligned)
   );

   // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept) next_state = steer_misaligned ? ST_RESP : ST_BUS;
         ST_BUS:  if (!waitrequest) next_state = ST_RESP;
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         writedata  <= '0;
         byteenable <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         rr_ptr     <= IDW'(NUM_PORTS - 1);
         lat_id     <= '0;
         lat_write  <= 1'b0;
         lat_size   <= SZ_BYTE;
         lat_signed <= 1'b0;
         lat_off    <= '0;
      end else begin
         rsp_valid <= '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rr_ptr     <= grant_id;
                  lat_id     <= grant_id;
                  lat_write  <= win_write;
                  lat_size   <= win_size;
                  lat_signed <= win_signed;
                  lat_off    <= win_addr[L-1:0];
                  if (steer_misaligned) begin
                     // Rejected without touching the bus.
                     rsp_valid <= NUM_PORTS'(1) << grant_id;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     read       <= !win_write;
                     write      <= win_write;
                     address    <= {win_addr[ADDR_W-1:L], {L{1'b0}}};
                     writedata  <= steer_wdata;
                     byteenable <= steer_be;
                  end
               end
            end
            ST_BUS: begin
               if (!waitrequest) begin
                  read      <= 1'b0;
                  write     <= 1'b0;
                  rsp_valid <= NUM_PORTS'(1) << lat_id;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= lat_write ? '0 : steer_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_mm_multiport_master.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops and
// compares on every rsp_valid; Avalon-side timing is checked inline.
module tb_avalon_mm_multiport_master;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready, req_ready_fp;
   logic [1:0]  req_write, req_signed;
   logic [63:0] req_addr, req_wdata;
   logic [3:0]  req_size;
   logic [1:0]  rsp_valid, rsp_valid_fp;
   logic [31:0] rsp_rdata, rsp_rdata_fp;
   logic        rsp_err, rsp_err_fp;
   logic [31:0] address, address_fp;
   logic        read, write, read_fp, write_fp;
   logic        waitrequest;
   logic [31:0] writedata, writedata_fp, readdata;
   logic [3:0]  byteenable, byteenable_fp;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   avalon_mm_multiport_master #(
      .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .address(address), .read(read), .write(write),
      .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata)
   );

   // Fixed-priority twin, used only to check arbitration.
   avalon_mm_multiport_master #(
      .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)
   ) dut_fp (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready_fp), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_fp), .rsp_rdata(rsp_rdata_fp),
      .rsp_err(rsp_err_fp), .address(address_fp), .read(read_fp), .write(write_fp),
      .waitrequest(waitrequest), .writedata(writedata_fp),
      .byteenable(byteenable_fp), .readdata(readdata)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int port, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.port  = port;
      e.rdata = rdata;
      e.err   = err;
      exp_q.push_back(e);
   endtask

   // Presents a request on port p, waits (bounded) for the grant, then
   // scrambles the port's inputs right after the accepting edge.
   task automatic issue(input int p, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic sg, input logic [31:0] wd);
      logic seen;
      seen = 1'b0;
      req_write[p]          = w;
      req_addr[p*32 +: 32]  = a;
      req_size[p*2 +: 2]    = sz;
      req_signed[p]         = sg;
      req_wdata[p*32 +: 32] = wd;
      req_valid[p]          = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = req_ready[p];
      end
      check("accept", seen, 1);
      @(posedge clk);
      #1;
      req_valid[p]          = 1'b0;
      req_write[p]          = ~w;
      req_addr[p*32 +: 32]  = 32'hFFFF_FFFF;
      req_size[p*2 +: 2]    = ~sz;
      req_signed[p]         = ~sg;
      req_wdata[p*32 +: 32] = ~wd;
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Monitor: every response pulse must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", rsp_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_port",  rsp_valid, 2'b01 << e.port);
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err",   rsp_err,   e.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      req_valid   = 2'b11;
      req_write   = '0;
      req_addr    = '0;
      req_size    = '0;
      req_signed  = '0;
      req_wdata   = '0;
      waitrequest = 1'b0;
      readdata    = '0;

      // Reset state, with requests pending that must not be granted.
      @(negedge clk);
      check("rst_read",       read, 0);
      check("rst_write",      write, 0);
      check("rst_address",    address, 0);
      check("rst_byteenable", byteenable, 0);
      check("rst_writedata",  writedata, 0);
      check("rst_rsp_valid",  rsp_valid, 0);
      check("rst_rsp_rdata",  rsp_rdata, 0);
      check("rst_rsp_err",    rsp_err, 0);
      check("rst_req_ready",  req_ready, 0);
      check("rst_req_ready_fp", req_ready_fp, 0);
      req_valid = 2'b00;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Aligned word read, zero wait states.
      readdata = 32'hDEAD_BEEF;
      push(0, 32'hDEAD_BEEF, 1'b0);
      issue(0, 1'b0, 32'h104, 2'b10, 1'b0, 32'h0);
      @(negedge clk);
      check("w_read",       read, 1);
      check("w_write",      write, 0);
      check("w_address",    address, 32'h104);
      check("w_byteenable", byteenable, 4'hF);
      check("w_rsp_early",  rsp_valid, 0);
      @(negedge clk);
      check("w_rsp_t2",     rsp_valid, 2'b01);
      check("w_read_drop",  read, 0);
      drain();

      // Signed and unsigned byte reads at lane 3.
      readdata = 32'h8011_2233;
      push(1, 32'hFFFF_FF80, 1'b0);
      issue(1, 1'b0, 32'h203, 2'b00, 1'b1, 32'h0);
      @(negedge clk);
      check("sb_address",    address, 32'h200);
      check("sb_byteenable", byteenable, 4'b1000);
      check("sb_read",       read, 1);
      drain();
      push(1, 32'h0000_0080, 1'b0);
      issue(1, 1'b0, 32'h203, 2'b00, 1'b0, 32'h0);
      drain();

      // Signed halfword read at lane 2.
      push(0, 32'hFFFF_8011, 1'b0);
      issue(0, 1'b0, 32'h202, 2'b01, 1'b1, 32'h0);
      @(negedge clk);
      check("sh_byteenable", byteenable, 4'b1100);
      drain();

      // Halfword write stalled by waitrequest for three cycles.
      waitrequest = 1'b1;
      push(0, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h32, 2'b01, 1'b0, 32'h1234_ABCD);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("hw_write",      write, 1);
         check("hw_read",       read, 0);
         check("hw_address",    address, 32'h30);
         check("hw_byteenable", byteenable, 4'b1100);
         check("hw_wdata_hi",   writedata[31:16], 16'hABCD);
         check("hw_no_rsp",     rsp_valid, 0);
      end
      waitrequest = 1'b0;
      @(negedge clk);
      check("hw_write_drop", write, 0);
      check("hw_rsp",        rsp_valid, 2'b01);
      drain();

      // Byte write at lane 1.
      push(1, 32'h0, 1'b0);
      issue(1, 1'b1, 32'h41, 2'b00, 1'b0, 32'hAAAA_BB55);
      @(negedge clk);
      check("bw_address",    address, 32'h40);
      check("bw_byteenable", byteenable, 4'b0010);
      check("bw_wdata_lane", writedata[15:8], 8'h55);
      drain();

      // Dword on a 32-bit bus is illegal.
      push(0, 32'h0, 1'b1);
      issue(0, 1'b0, 32'h100, 2'b11, 1'b0, 32'h0);
      @(negedge clk);
      check("dw_no_read", read, 0);
      check("dw_rsp",     rsp_valid, 2'b01);
      drain();

      // Misaligned word read: error one cycle after accept, no strobe.
      readdata = 32'hFFFF_FFFF;
      push(1, 32'h0, 1'b1);
      issue(1, 1'b0, 32'h102, 2'b10, 1'b0, 32'h0);
      @(negedge clk);
      check("mis_no_read",  read, 0);
      check("mis_no_write", write, 0);
      check("mis_rsp",      rsp_valid, 2'b10);
      @(negedge clk);
      check("mis_no_read2", read, 0);
      check("mis_rsp_gone", rsp_valid, 0);
      drain();

      // Both ports continuously valid: RR alternates, fixed priority keeps port 0.
      readdata = 32'hCAFE_F00D;
      for (int n = 0; n < 4; n++) push(n % 2, 32'hCAFE_F00D, 1'b0);
      req_write  = 2'b00;
      req_signed = 2'b00;
      req_size   = 4'b1010;
      req_addr   = {32'h4, 32'h0};
      req_valid  = 2'b11;
      for (int n = 0; n < 4; n++) begin
         logic got;
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (req_ready != 2'b00);
         end
         check("rr_grant", req_ready, 2'b01 << (n % 2));
         check("fp_grant", req_ready_fp, 2'b01);
         @(posedge clk);
         #1;
      end
      req_valid = 2'b00;
      drain();

      // Reset in the middle of a stalled read aborts it silently.
      waitrequest = 1'b1;
      readdata    = 32'h1111_1111;
      issue(0, 1'b0, 32'h300, 2'b10, 1'b0, 32'h0);
      @(negedge clk);
      check("ab_read_on", read, 1);
      #2;
      reset = 1'b0;
      #1;
      check("ab_read",       read, 0);
      check("ab_byteenable", byteenable, 0);
      check("ab_write",      write, 0);
      check("ab_rsp",        rsp_valid, 0);
      waitrequest = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ab_no_rsp", rsp_valid, 0);
      end

      // Service resumes normally after reset.
      readdata = 32'h0123_4567;
      push(1, 32'h0123_4567, 1'b0);
      @(posedge clk);
      #1;
      issue(1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      @(negedge clk);
      check("post_address", address, 32'h10);
      check("post_read",    read, 1);
      drain();

      check("sb_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
